// File: rtl/vga_seq_ctrl.sv
// ============================================================================
// vga_seq_ctrl
// ----------------------------------------------------------------------------
// Reset/enable sequencer for the VGA driver datapath.
//
// This block turns the board-level asynchronous reset into a timed sequence
// for the timing generator and pixel pipeline:
//   1. a registered reset-hold phase (drv_rst high), then
//   2. an enable-delay phase (both low), then
//   3. the run phase (drv_en high).
// While running it accepts run-time start, stop and soft-reset requests.
// In the frame-sync build it can also hold the enable until the end of the
// current frame.
//
// Build option:
//   VGA_SEQ_FRAME_SYNC_EN
//     - defined:   stop_req in S_RUN enters S_STOP. drv_en then holds until
//                  frame_end, so the last frame is always completed.
//     - undefined: stop_req in S_RUN goes straight to S_IDLE, S_STOP is never
//                  entered and frame_end is ignored.
//
// Parameters:
//   HOLD_CYCLES : edges drv_rst stays high after reset release or soft reset
//                 (>= 1)
//   EN_DELAY    : edges between drv_rst falling and drv_en rising (>= 1)
//   CNT_W       : internal counter width; HOLD_CYCLES and EN_DELAY must both
//                 be <= 2**CNT_W
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   soft_rst_req  in   single-cycle pulse; restarts the full sequence from
//                      any state
//   start_req     in   single-cycle pulse; leaves S_IDLE for S_WAIT
//   stop_req      in   single-cycle pulse; requests disable
//   frame_end     in   single-cycle pulse at the last pixel of a frame
//   drv_rst       out  registered active-high reset to the driver
//   drv_en        out  registered enable to the driver
//   busy          out  high in S_RST, S_WAIT and S_STOP
//   state         out  current state code
//                      (0 RST, 1 WAIT, 2 RUN, 3 STOP, 4 IDLE)
// ============================================================================
module vga_seq_ctrl #(
    parameter int HOLD_CYCLES = 5,
    parameter int EN_DELAY    = 5,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst_req,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       frame_end,
    output logic       drv_rst,
    output logic       drv_en,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_WAIT = 3'd1,
        S_RUN  = 3'd2,
        S_STOP = 3'd3,
        S_IDLE = 3'd4
    } state_t;

    // Terminal counts. The counter starts at 0, so a phase of N edges ends
    // when the counter equals N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_DELAY - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             drv_rst_q;
    logic             drv_rst_d;
    logic             drv_en_q;
    logic             drv_en_d;
    logic             busy_q;
    logic             busy_d;

    // Saturating increment. The counter holds at all-ones instead of
    // wrapping back to zero.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // ------------------------------------------------------------------------
    // Next-state logic.
    // soft_rst_req is applied last so that it overrides every other decision.
    // Within a state, stop_req is checked before the counter terminal count
    // and before start_req.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_RST: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_WAIT: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == EN_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_RUN: begin
                if (stop_req) begin
`ifdef VGA_SEQ_FRAME_SYNC_EN
                    // If the frame is already ending in this cycle there is
                    // nothing left to wait for, so go straight to idle.
                    state_d = frame_end ? S_IDLE : S_STOP;
`else
                    state_d = S_IDLE;
`endif
                end
            end

            S_STOP: begin
`ifdef VGA_SEQ_FRAME_SYNC_EN
                if (frame_end) begin
                    state_d = S_IDLE;
                end
`else
                // This state cannot be reached in this build. If it is ever
                // entered, fall back to idle.
                state_d = S_IDLE;
`endif
            end

            S_IDLE: begin
                // Restart goes through the enable delay only. The driver is
                // not reset again.
                if (start_req) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase

        if (soft_rst_req) begin
            state_d = S_RST;
            cnt_d   = '0;
        end
    end

`ifndef VGA_SEQ_FRAME_SYNC_EN
    // frame_end has no function without frame sync. It is tied off here so
    // the port still has a load.
    logic frame_end_unused;
    assign frame_end_unused = frame_end;
`endif

    // Outputs are decoded from the next state, so each one changes on the
    // same edge as the state register.
    always_comb begin
        drv_rst_d = (state_d == S_RST);
        drv_en_d  = (state_d == S_RUN) || (state_d == S_STOP);
        busy_d    = (state_d == S_RST) || (state_d == S_WAIT) ||
                    (state_d == S_STOP);
    end

    // ------------------------------------------------------------------------
    // State, counter and output registers.
    // rst forces the reset values at once, with no dependence on clk.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            cnt_q     <= '0;
            drv_rst_q <= 1'b1;
            drv_en_q  <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drv_rst_q <= drv_rst_d;
            drv_en_q  <= drv_en_d;
            busy_q    <= busy_d;
        end
    end

    assign drv_rst = drv_rst_q;
    assign drv_en  = drv_en_q;
    assign busy    = busy_q;
    assign state   = state_q;

endmodule
